// File: rtl/write_arbiter_pkg.sv
// Shared widths, the packed write-port record and helper functions for write_arbiter.
// Optional statistics counters are enabled with the WRITE_ARB_STAT_EN macro.
package write_arbiter_pkg;

    localparam int unsigned LEN_WORD             = 32;
    localparam int unsigned LEN_PREG_ADDR        = 6;
    localparam int unsigned LEN_CONTEXT          = 2;
    localparam int unsigned LEN_WRITE_D_R        = 1 + LEN_PREG_ADDR + LEN_WORD;
    localparam int unsigned WRITE_ARB_N_REQ      = 3;
    localparam int unsigned WRITE_ARB_LEN_REQ_ID = 2;

    localparam logic [LEN_CONTEXT-1:0] CONTEXT_ZERO = '0;

    typedef struct packed {
        logic                     order;
        logic [LEN_PREG_ADDR-1:0] pa_rd;
        logic [LEN_WORD-1:0]      data;
    } write_d_r_t;

    function automatic logic [LEN_WRITE_D_R-1:0] pack_struct_write_d_r(input write_d_r_t s);
        return s;
    endfunction

    // Assumes at most one bit set; an all-zero input maps to index 0.
    function automatic logic [31:0] onehot_to_binary(input logic [31:0] onehot);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                bin = bin | 32'(i);
            end
        end
        return bin;
    endfunction

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/write_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after the pointer,
// wrapping modulo N_REQ.
module write_arbiter_rr_picker
    import write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = WRITE_ARB_N_REQ,
    parameter int unsigned LEN_REQ_ID = WRITE_ARB_LEN_REQ_ID
) (
    input  logic [N_REQ-1:0]      i_eligible,
    input  logic [LEN_REQ_ID-1:0] i_rr_ptr,
    output logic [N_REQ-1:0]      o_grant,
    output logic [LEN_REQ_ID-1:0] o_grant_id,
    output logic                  o_any
);

    logic [N_REQ-1:0]    w_grant;
    logic                w_found;
    logic [LEN_REQ_ID:0] w_pos;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Pointer is always < N_REQ, so one subtraction completes the wrap.
            w_pos = {1'b0, i_rr_ptr} + (LEN_REQ_ID+1)'(k);
            if (w_pos >= (LEN_REQ_ID+1)'(N_REQ)) begin
                w_pos = w_pos - (LEN_REQ_ID+1)'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && (w_pos == (LEN_REQ_ID+1)'(j)) && i_eligible[j]) begin
                    w_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    assign o_grant    = w_grant;
    assign o_grant_id = LEN_REQ_ID'(onehot_to_binary(32'(w_grant)));
    assign o_any      = |i_eligible;

endmodule

// File: rtl/write_arbiter.sv
// Shares the single register-file write port among N_REQ requesters via one-entry slots,
// round-robin selection and context flush. WRITE_ARB_STAT_EN adds statistics counters.
module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = WRITE_ARB_N_REQ,
    parameter int unsigned LEN_REQ_ID = WRITE_ARB_LEN_REQ_ID
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*LEN_PREG_ADDR-1:0] req_pa_rd,
    input  logic [N_REQ*LEN_WORD-1:0]      req_data,
    input  logic [N_REQ*LEN_CONTEXT-1:0]   req_context,
    input  logic                           branch_hazard,
    input  logic [LEN_CONTEXT-1:0]         hazard_context_info,
    output logic [LEN_WRITE_D_R-1:0]       w_write_d_r,
    output logic [LEN_REQ_ID-1:0]          grant_id
`ifdef WRITE_ARB_STAT_EN
    ,
    output logic [31:0]                    stat_conflict,
    output logic [31:0]                    stat_flush
`endif
);

    logic [N_REQ-1:0]         r_slot_valid;
    logic [LEN_PREG_ADDR-1:0] r_pa_rd   [N_REQ];
    logic [LEN_WORD-1:0]      r_data    [N_REQ];
    logic [LEN_CONTEXT-1:0]   r_context [N_REQ];
    logic [LEN_REQ_ID-1:0]    r_rr_ptr;

    logic [N_REQ-1:0]         w_kill_slot;
    logic [N_REQ-1:0]         w_kill_in;
    logic [N_REQ-1:0]         w_eligible;
    logic [N_REQ-1:0]         w_grant;
    logic [LEN_REQ_ID-1:0]    w_grant_id;
    logic                     w_any;
    logic [N_REQ-1:0]         w_ready;
    logic [N_REQ-1:0]         w_load;
    logic [LEN_PREG_ADDR-1:0] w_out_pa;
    logic [LEN_WORD-1:0]      w_out_data;
    logic [LEN_REQ_ID-1:0]    w_rr_next;
    write_d_r_t               w_write;

    always_comb begin
        w_kill_slot = '0;
        w_kill_in   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_kill_slot[i] = r_slot_valid[i] & branch_hazard
                           & (|(r_context[i] & hazard_context_info));
            w_kill_in[i]   = branch_hazard
                           & (|(req_context[i*LEN_CONTEXT +: LEN_CONTEXT] & hazard_context_info));
        end
    end

    assign w_eligible = r_slot_valid & ~w_kill_slot;

    write_arbiter_rr_picker #(
        .N_REQ      (N_REQ),
        .LEN_REQ_ID (LEN_REQ_ID)
    ) u_rr_picker (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // Ready is independent of req_valid, so no combinational loop through requesters.
    assign w_ready   = ~r_slot_valid | w_grant | w_kill_slot;
    assign req_ready = w_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_load[i] = req_valid[i] & w_ready[i] & ~w_kill_in[i]
                      & (req_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR] != '0);
        end
    end

    always_comb begin
        w_out_pa   = '0;
        w_out_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_out_pa   = r_pa_rd[i];
                w_out_data = r_data[i];
            end
        end
    end

    assign w_write.order = w_any;
    assign w_write.pa_rd = w_out_pa;
    assign w_write.data  = w_out_data;
    assign w_write_d_r   = pack_struct_write_d_r(w_write);
    assign grant_id      = w_grant_id;

    assign w_rr_next = (w_grant_id == LEN_REQ_ID'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slot_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_pa_rd[i]   <= '0;
                r_data[i]    <= '0;
                r_context[i] <= CONTEXT_ZERO;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_load[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_pa_rd[i]      <= req_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
                    r_data[i]       <= req_data[i*LEN_WORD +: LEN_WORD];
                    r_context[i]    <= req_context[i*LEN_CONTEXT +: LEN_CONTEXT];
                end else if (w_grant[i] | w_kill_slot[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef WRITE_ARB_STAT_EN
    logic [31:0] r_stat_conflict;
    logic [31:0] r_stat_flush;
    logic [31:0] w_flush_inc;
    logic [32:0] w_flush_sum;

    assign w_flush_inc = popcount(32'(w_kill_slot))
                       + popcount(32'(w_kill_in & req_valid & w_ready));
    assign w_flush_sum = {1'b0, r_stat_flush} + {1'b0, w_flush_inc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_conflict <= '0;
            r_stat_flush    <= '0;
        end else begin
            if (popcount(32'(w_eligible)) > 32'd1) begin
                r_stat_conflict <= r_stat_conflict + 32'd1;
            end
            r_stat_flush <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end

    assign stat_conflict = r_stat_conflict;
    assign stat_flush    = r_stat_flush;
`endif

endmodule

// File: tb/tb_write_arbiter.sv
// Directed, table-driven bench for write_arbiter: per-cycle stimulus with
// hand-computed write-port and ready expectations, plus reset sequences.
module tb_write_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [17:0] req_pa_rd;
    logic [95:0] req_data;
    logic [5:0]  req_context;
    logic        branch_hazard;
    logic [1:0]  hazard_context_info;
    logic [38:0] w_write_d_r;
    logic [1:0]  grant_id;

    int n_tests;
    int n_fail;

    write_arbiter dut (
        .clk                 (clk),
        .rstn                (rstn),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_pa_rd           (req_pa_rd),
        .req_data            (req_data),
        .req_context         (req_context),
        .branch_hazard       (branch_hazard),
        .hazard_context_info (hazard_context_info),
        .w_write_d_r         (w_write_d_r),
        .grant_id            (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  valid;
        logic [17:0] pa;
        logic [95:0] data;
        logic [5:0]  ctx;
        logic        hz;
        logic [1:0]  hinfo;
        logic        eord;
        logic [5:0]  epa;
        logic [31:0] edata;
        logic [1:0]  egid;
        logic [2:0]  erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [2:0] valid,
                       input logic [5:0] pa0, input logic [5:0] pa1, input logic [5:0] pa2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [5:0] ctx, input logic hz, input logic [1:0] hinfo,
                       input logic eord, input logic [5:0] epa, input logic [31:0] edata,
                       input logic [1:0] egid, input logic [2:0] erdy);
        vec_t v;
        v.rst = rst;     v.valid = valid;  v.pa = {pa2, pa1, pa0};
        v.data = {d2, d1, d0}; v.ctx = ctx; v.hz = hz; v.hinfo = hinfo;
        v.eord = eord;   v.epa = epa;      v.edata = edata;
        v.egid = egid;   v.erdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req_valid = '0; req_pa_rd = '0; req_data = '0; req_context = '0;
        branch_hazard = 1'b0; hazard_context_info = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Packs observed outputs as {order, pa_rd, data, grant_id (masked when idle), ready}.
    function automatic logic [63:0] observed();
        logic ord;
        ord = w_write_d_r[38];
        return {20'd0, ord, w_write_d_r[37:32], w_write_d_r[31:0],
                (ord ? grant_id : 2'b00), req_ready};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        drive_idle();

        // Outputs are reset-derived even before the first edge.
        #2;
        check("in_reset", observed(), {20'd0, 1'b0, 6'd0, 32'd0, 2'd0, 3'b111});
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle_%0d", c), observed(),
                  {20'd0, 1'b0, 6'd0, 32'd0, 2'd0, 3'b111});
        end

        //  rst valid   pa0 pa1 pa2 d0 d1 d2 ctx hz hinfo | ord pa data gid rdy
        // Single write: accepted at edge N, visible in cycle N+1 only.
        add(1, 3'b001, 6'd5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 6'd5, 32'hDEADBEEF, 2'd0, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        // Fairness: three contending requesters hold data until accepted.
        add(1, 3'b111, 1, 2, 3, 32'hA0, 32'hB0, 32'hC0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        add(0, 3'b111, 1, 2, 3, 32'hA1, 32'hB1, 32'hC1, 0, 0, 0,  1, 1, 32'hA0, 0, 3'b001);
        add(0, 3'b111, 1, 2, 3, 32'hA2, 32'hB1, 32'hC1, 0, 0, 0,  1, 2, 32'hB0, 1, 3'b010);
        add(0, 3'b111, 1, 2, 3, 32'hA2, 32'hB2, 32'hC1, 0, 0, 0,  1, 3, 32'hC0, 2, 3'b100);
        add(0, 3'b111, 1, 2, 3, 32'hA2, 32'hB2, 32'hC2, 0, 0, 0,  1, 1, 32'hA1, 0, 3'b001);
        add(0, 3'b111, 1, 2, 3, 32'hA3, 32'hB2, 32'hC2, 0, 0, 0,  1, 2, 32'hB1, 1, 3'b010);
        add(0, 3'b111, 1, 2, 3, 32'hA3, 32'hB3, 32'hC2, 0, 0, 0,  1, 3, 32'hC1, 2, 3'b100);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 32'hA2, 0, 3'b001);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 32'hB2, 1, 3'b011);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 32'hC2, 2, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        // Flush: slot1 ctx 10 killed, slot2 ctx 01 written in the same cycle.
        add(1, 3'b110, 0, 7, 8, 0, 32'h11, 32'h22, 6'b01_10_00, 0, 0,  0, 0, 0, 0, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10,  1, 8, 32'h22, 2, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        // Killed incoming request is accepted and dropped.
        add(0, 3'b001, 9, 0, 0, 32'h33, 0, 0, 6'b00_00_10, 1, 2'b10,  0, 0, 0, 0, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        // Register 0 request is accepted but never written.
        add(0, 3'b100, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        // Back-pressure: requester 0 sends D0..D3 against a permanently valid requester 1.
        add(1, 3'b011, 10, 20, 0, 32'hD0, 32'hE0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);
        add(0, 3'b011, 10, 20, 0, 32'hD1, 32'hE1, 0, 0, 0, 0,  1, 10, 32'hD0, 0, 3'b101);
        add(0, 3'b011, 10, 20, 0, 32'hD2, 32'hE1, 0, 0, 0, 0,  1, 20, 32'hE0, 1, 3'b110);
        add(0, 3'b011, 10, 20, 0, 32'hD2, 32'hE2, 0, 0, 0, 0,  1, 10, 32'hD1, 0, 3'b101);
        add(0, 3'b011, 10, 20, 0, 32'hD3, 32'hE2, 0, 0, 0, 0,  1, 20, 32'hE1, 1, 3'b110);
        add(0, 3'b011, 10, 20, 0, 32'hD3, 32'hE3, 0, 0, 0, 0,  1, 10, 32'hD2, 0, 3'b101);
        add(0, 3'b010, 0, 20, 0, 0, 32'hE3, 0, 0, 0, 0,  1, 20, 32'hE2, 1, 3'b110);
        add(0, 3'b010, 0, 20, 0, 0, 32'hE4, 0, 0, 0, 0,  1, 10, 32'hD3, 0, 3'b101);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 20, 32'hE3, 1, 3'b111);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'b111);

        foreach (vecs[n]) begin
            if (vecs[n].rst) begin
                do_reset();
            end
            @(negedge clk);
            req_valid           = vecs[n].valid;
            req_pa_rd           = vecs[n].pa;
            req_data            = vecs[n].data;
            req_context         = vecs[n].ctx;
            branch_hazard       = vecs[n].hz;
            hazard_context_info = vecs[n].hinfo;
            #1;
            check($sformatf("vec%0d", n), observed(),
                  {20'd0, vecs[n].eord, vecs[n].epa, vecs[n].edata,
                   vecs[n].egid, vecs[n].erdy});
        end

        // Mid-operation reset discards held writes immediately.
        do_reset();
        @(negedge clk);
        req_valid = 3'b111;
        req_pa_rd = {6'd3, 6'd2, 6'd1};
        req_data  = {32'hC5, 32'hB5, 32'hA5};
        @(negedge clk);
        drive_idle();
        #1;
        check("pre_reset_full", observed(), {20'd0, 1'b1, 6'd1, 32'hA5, 2'd0, 3'b001});
        #1;
        rstn = 1'b0;
        #1;
        check("async_reset_drop", observed(), {20'd0, 1'b0, 6'd0, 32'd0, 2'd0, 3'b111});
        check("async_reset_gid", {62'd0, grant_id}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_empty", observed(), {20'd0, 1'b0, 6'd0, 32'd0, 2'd0, 3'b111});
        @(negedge clk);
        #1;
        check("post_reset_empty2", observed(), {20'd0, 1'b0, 6'd0, 32'd0, 2'd0, 3'b111});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
